// File: rtl/vga_sync_checker.sv
// vga_sync_checker
//   Monitors the sync and colour outputs of a VGA timing generator and
//   reports whether the stream matches the configured timing.
//
//   The checker hunts for a frame start (SEEK). It then measures one clean
//   frame (MEASURE) and declares lock (LOCKED). Timing or blanking
//   violations are latched into sticky flags and counted.
//
// Ports
//   clk_40      : pixel clock; all logic runs on its rising edge
//   reset       : synchronous, active-high reset
//   h_sync      : horizontal sync, positive polarity
//   v_sync      : vertical sync, positive polarity
//   color_r_i   : red colour bit from the output stage
//   color_g_i   : green colour bit from the output stage
//   color_b_i   : blue colour bit from the output stage
//   locked      : high while the stream is locked
//   err_flags   : sticky flags
//                   [0] h period, [1] h width, [2] v period,
//                   [3] v width,  [4] colour in blanking
//   err_count   : clocks with at least one new violation, saturates at 255
//   frame_count : frames completed while locked, wraps at 16 bits
module vga_sync_checker #(
  parameter int unsigned H_TOTAL  = 1056,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BACK   = 88,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_TOTAL  = 628,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BACK   = 23,
  parameter int unsigned V_ACTIVE = 600
) (
  input  logic        clk_40,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        color_r_i,
  input  logic        color_g_i,
  input  logic        color_b_i,
  output logic        locked,
  output logic [4:0]  err_flags,
  output logic [7:0]  err_count,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
  localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
  localparam logic [11:0] H_ACT_LO  = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT_HI  = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_LO  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_HI  = 11'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [10:0] HCNT_MAX  = 11'h7FF;
  localparam logic [9:0]  VCNT_MAX  = 10'h3FF;

  // Input pipeline
  logic        hs_q;
  logic        vs_q;
  logic        hs_dly_q;
  logic        vs_dly_q;
  logic [2:0]  rgb_q;

  // Counters and status
  logic [10:0] hcnt_q;
  logic [10:0] hcnt_d;
  logic [9:0]  vcnt_q;
  logic [9:0]  vcnt_d;
  logic [4:0]  flags_q;
  logic [4:0]  flags_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic [15:0] frame_q;

  // FSM state
  state_e      state_q;
  logic        locked_q;
  logic        skip_q;
  logic        err_seen_q;

  // Combinational decode
  logic        h_rise_s;
  logic        h_fall_s;
  logic        v_rise_s;
  logic        v_fall_s;
  logic [11:0] hcnt_inc_s;
  logic [10:0] vcnt_inc_s;
  logic        h_lost_s;
  logic        v_lost_s;
  logic        active_s;
  logic [4:0]  viol_s;
  logic        any_viol_s;
  logic        lost_s;

  assign h_rise_s   = hs_q & ~hs_dly_q;
  assign h_fall_s   = ~hs_q & hs_dly_q;
  assign v_rise_s   = vs_q & ~vs_dly_q;
  assign v_fall_s   = ~vs_q & vs_dly_q;
  assign hcnt_inc_s = {1'b0, hcnt_q} + 12'd1;
  assign vcnt_inc_s = {1'b0, vcnt_q} + 11'd1;

  // "Lost" fires only on the clock the counter first reaches saturation.
  assign h_lost_s = (hcnt_d == HCNT_MAX) && (hcnt_q != HCNT_MAX);
  assign v_lost_s = (vcnt_d == VCNT_MAX) && (vcnt_q != VCNT_MAX);

  // hcnt_q trails the pixel index by one clock, because it clears one clock
  // after the registered sync edge. The next-state counts line up with the
  // registered colour sample, so the region test uses them.
  assign active_s = ({1'b0, hcnt_d} >= H_ACT_LO) && ({1'b0, hcnt_d} < H_ACT_HI) &&
                    ({1'b0, vcnt_d} >= V_ACT_LO) && ({1'b0, vcnt_d} < V_ACT_HI);

  assign any_viol_s = |viol_s;
  assign lost_s     = (state_q != SEEK) && (h_lost_s || v_lost_s);

  // Next-state values for the line and frame counters
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (h_rise_s) begin
      hcnt_d = 11'd0;
    end else if (hcnt_q != HCNT_MAX) begin
      hcnt_d = hcnt_q + 11'd1;
    end else begin
      hcnt_d = hcnt_q;
    end
    // A v_sync rise clears the line count, even when h_sync rises on the same clock.
    if (v_rise_s) begin
      vcnt_d = 10'd0;
    end else if (h_rise_s && (vcnt_q != VCNT_MAX)) begin
      vcnt_d = vcnt_q + 10'd1;
    end else begin
      vcnt_d = vcnt_q;
    end
  end

  // Violation detection; nothing is checked while hunting for a frame start
  always_comb begin
    viol_s = 5'b00000;
    if (state_q != SEEK) begin
      viol_s[0] = (h_rise_s && !skip_q && (hcnt_inc_s != H_TOTAL_C)) || h_lost_s;
      viol_s[1] = h_fall_s && (hcnt_inc_s != H_SYNC_C);
      viol_s[2] = (v_rise_s && (vcnt_inc_s != V_TOTAL_C)) || v_lost_s;
      viol_s[3] = v_fall_s && (vcnt_inc_s != V_SYNC_C);
      viol_s[4] = (|rgb_q) && !active_s;
    end else begin
      viol_s = 5'b00000;
    end
  end

  // Sticky flags and the saturating error counter
  always_comb begin
    flags_d = flags_q | viol_s;
    cnt_d   = cnt_q;
    if (any_viol_s && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Input registers, edge-detect delay stage, counters and error status
  always_ff @(posedge clk_40) begin
    if (reset) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      hs_dly_q <= 1'b0;
      vs_dly_q <= 1'b0;
      rgb_q    <= 3'b000;
      hcnt_q   <= 11'd0;
      vcnt_q   <= 10'd0;
      flags_q  <= 5'b00000;
      cnt_q    <= 8'd0;
    end else begin
      hs_q     <= h_sync;
      vs_q     <= v_sync;
      hs_dly_q <= hs_q;
      vs_dly_q <= vs_q;
      rgb_q    <= {color_r_i, color_g_i, color_b_i};
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
    end
  end

  // Lock FSM with registered lock output and frame counter
  always_ff @(posedge clk_40) begin
    if (reset) begin
      state_q    <= SEEK;
      locked_q   <= 1'b0;
      skip_q     <= 1'b0;
      err_seen_q <= 1'b0;
      frame_q    <= 16'd0;
    end else begin
      // The first line measured after SEEK may be partial, so its period is not judged.
      if (h_rise_s) begin
        skip_q <= 1'b0;
      end
      case (state_q)
        SEEK: begin
          if (v_rise_s) begin
            state_q    <= MEASURE;
            skip_q     <= 1'b1;
            err_seen_q <= 1'b0;
          end
        end
        MEASURE: begin
          if (lost_s) begin
            state_q <= SEEK;
          end else if (v_rise_s) begin
            if (!err_seen_q && !any_viol_s) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
            err_seen_q <= 1'b0;
          end else if (any_viol_s) begin
            err_seen_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (lost_s) begin
            state_q  <= SEEK;
            locked_q <= 1'b0;
          end else if (any_viol_s) begin
            state_q    <= MEASURE;
            locked_q   <= 1'b0;
            err_seen_q <= 1'b0;
          end else if (v_rise_s) begin
            frame_q <= frame_q + 16'd1;
          end
        end
        default: begin
          state_q  <= SEEK;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked      = locked_q;
  assign err_flags   = flags_q;
  assign err_count   = cnt_q;
  assign frame_count = frame_q;

endmodule
